// File: rtl/wb_uart_master_pkg.sv
// Shared definitions for the UART bus initiator: register map, wb_we polarity,
// FSM state encoding and the timeout counter width.
package wb_uart_master_pkg;

    localparam logic [1:0] TX_DATA_ADDR  = 2'b00;
    localparam logic [1:0] RX_DATA_ADDR  = 2'b01;
    localparam logic [1:0] FREQ_DIV_ADDR = 2'b10;

    // The UART bus uses inverted write-enable polarity: 0 writes, 1 reads.
    localparam logic WB_WE_WRITE = 1'b0;
    localparam logic WB_WE_READ  = 1'b1;

    localparam int TMO_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } wb_state_e;

    function automatic logic wb_we_for(input logic req_write);
        return req_write ? WB_WE_WRITE : WB_WE_READ;
    endfunction

endpackage

// File: rtl/wb_uart_master_if.sv
// UART register-bus signals between the initiator (master) and the UART (slave).
interface wb_uart_master_if;

    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_clk;
    logic       wb_ack;

    modport master (
        output wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        input  wb_data_in, wb_ack
    );

    modport slave (
        input  wb_addr, wb_data_out, wb_we, wb_stb, wb_clk,
        output wb_data_in, wb_ack
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Transaction watchdog: clears on request acceptance, counts while enabled and
// flags expiry on the cycle the count reaches LIMIT.
module wb_timeout_counter
    import wb_uart_master_pkg::*;
#(
    parameter logic [TMO_WIDTH-1:0] LIMIT = 16'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMO_WIDTH-1:0] count;
    logic [TMO_WIDTH-1:0] count_next;

    // LIMIT never exceeds 65535, so count + 1 cannot wrap before it matches.
    assign count_next = count + 1'b1;
    assign expire     = enable && (count_next == LIMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/wb_uart_master.sv
// Single-outstanding bus initiator for the UART register port.
// Define WB_MASTER_TIMEOUT_EN to build in the transaction timeout/abort path.
module wb_uart_master
    import wb_uart_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_addr,
    input  logic [7:0]              req_wdata,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_rdata,
    output logic                    rsp_timeout,
    wb_uart_master_if.master        wb
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_uart_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    wb_state_e state;
    logic      accept;

    // A stale ack from an aborted or reset-interrupted transfer blocks new requests.
    assign req_ready = (state == ST_IDLE) && !wb.wb_ack;
    assign accept    = req_valid && req_ready;

`ifdef WB_MASTER_TIMEOUT_EN
    logic tmo_expire;

    wb_timeout_counter #(
        .LIMIT (TMO_WIDTH'(TIMEOUT_CYCLES))
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable ((state == ST_STROBE) || (state == ST_RELEASE)),
        .expire (tmo_expire)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            wb.wb_stb      <= 1'b0;
            wb.wb_clk      <= 1'b0;
            wb.wb_we       <= WB_WE_READ;
            wb.wb_addr     <= 2'b00;
            wb.wb_data_out <= 8'h00;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 8'h00;
            rsp_timeout    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wb.wb_addr     <= req_addr;
                        wb.wb_we       <= wb_we_for(req_write);
                        wb.wb_data_out <= req_write ? req_wdata : 8'h00;
                        wb.wb_stb      <= 1'b1;
                        state          <= ST_SETUP;
                    end
                end

                // One full cycle of address/data setup before the phase rises.
                ST_SETUP: begin
                    wb.wb_clk <= 1'b1;
                    state     <= ST_STROBE;
                end

                ST_STROBE: begin
                    if (wb.wb_ack) begin
                        wb.wb_clk <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end

                // Complete only once the responder has released ack.
                ST_RELEASE: begin
                    if (!wb.wb_ack) begin
                        rsp_rdata   <= (wb.wb_we == WB_WE_READ) ? wb.wb_data_in : 8'h00;
                        wb.wb_stb   <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase

`ifdef WB_MASTER_TIMEOUT_EN
            // Abort overrides any completion seen on the same edge.
            if (tmo_expire) begin
                wb.wb_stb   <= 1'b0;
                wb.wb_clk   <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= 8'h00;
                state       <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master with a small UART register responder model.
// Covers the timeout path when WB_MASTER_TIMEOUT_EN is defined, indefinite wait otherwise.
module tb_wb_uart_master;
    import wb_uart_master_pkg::*;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_timeout;

    wb_uart_master_if bus ();

    wb_uart_master #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .wb          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Responder model: acks one cycle after seeing the phase high, releases one
    // cycle after it falls; writes take effect on the first acked cycle.
    localparam logic [7:0] M_RX = 8'h5A;
    logic       ack_en;
    logic       hold_ack;
    logic [7:0] m_tx;
    logic [7:0] m_div;
    logic [7:0] tx_log[$];

    always @(posedge clk)
        bus.wb_ack <= hold_ack || (ack_en && bus.wb_stb && bus.wb_clk);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tx  <= 8'h00;
            m_div <= 8'h00;
        end else if (ack_en && bus.wb_stb && bus.wb_clk && !bus.wb_ack
                     && bus.wb_we == WB_WE_WRITE) begin
            case (bus.wb_addr)
                TX_DATA_ADDR: begin
                    m_tx <= bus.wb_data_out;
                    tx_log.push_back(bus.wb_data_out);
                end
                FREQ_DIV_ADDR: m_div <= bus.wb_data_out;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (bus.wb_addr)
            TX_DATA_ADDR:  bus.wb_data_in = m_tx;
            RX_DATA_ADDR:  bus.wb_data_in = M_RX;
            FREQ_DIV_ADDR: bus.wb_data_in = m_div;
            default:       bus.wb_data_in = 8'hFF;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   rsp_count = 0;
    int   rsp_b2b   = 0;
    logic rsp_prev  = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            if (rsp_prev) rsp_b2b++;
        end
        rsp_prev = (rsp_valid === 1'b1);
    end

    // Presents a request and returns on the negedge just after the accepting edge.
    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] d,
                         output logic ok);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Latency counts edges since the accepting edge.
    task automatic wait_rsp(input int bound, output logic got, output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < bound) begin
            @(negedge clk);
            lat++;
        end
        got = (rsp_valid === 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    logic ok, got;
    int   lat, c0, base;
    int   acc[3];

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 2'b00;
        req_wdata = 8'h00;
        ack_en    = 1'b1;
        hold_ack  = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.wb_stb, bus.wb_clk, bus.wb_we, bus.wb_addr, bus.wb_data_out,
               rsp_valid, rsp_timeout, rsp_rdata},
              {1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00});
        check("reset_ready", req_ready, 1'b1);
        reset = 1'b1;

        // Write TX 0x41.
        issue(1'b1, TX_DATA_ADDR, 8'h41, ok);
        check("wr_accept", ok, 1'b1);
        check("wr_bus", {bus.wb_stb, bus.wb_clk, bus.wb_we, bus.wb_addr, bus.wb_data_out},
              {1'b1, 1'b0, 1'b0, 2'b00, 8'h41});
        wait_rsp(20, got, lat);
        check("wr_rsp", got, 1'b1);
        check("wr_latency", lat, 5);
        check("wr_rsp_fields", {rsp_timeout, rsp_rdata}, {1'b0, 8'h00});
        check("wr_model_tx", m_tx, 8'h41);
        @(negedge clk);
        check("wr_rsp_one_cycle", rsp_valid, 1'b0);

        // Read RX.
        issue(1'b0, RX_DATA_ADDR, 8'hAA, ok);
        check("rd_accept", ok, 1'b1);
        check("rd_bus", {bus.wb_we, bus.wb_addr, bus.wb_data_out}, {1'b1, 2'b01, 8'h00});
        wait_rsp(20, got, lat);
        check("rd_rsp", got, 1'b1);
        check("rd_latency", lat, 5);
        check("rd_data", {rsp_timeout, rsp_rdata}, {1'b0, 8'h5A});

        // Divider write then RX read: exactly two responses.
        @(negedge clk); #1;
        c0 = rsp_count;
        issue(1'b1, FREQ_DIV_ADDR, 8'h4E, ok);
        wait_rsp(20, got, lat);
        check("div_wr_rsp", {got, rsp_timeout}, {1'b1, 1'b0});
        issue(1'b0, RX_DATA_ADDR, 8'h00, ok);
        wait_rsp(20, got, lat);
        check("div_rd_data", rsp_rdata, 8'h5A);
        @(negedge clk); #1;
        check("div_pulse_count", rsp_count - c0, 2);
        check("div_model_value", m_div, 8'd78);
        issue(1'b0, FREQ_DIV_ADDR, 8'h00, ok);
        wait_rsp(20, got, lat);
        check("div_readback", rsp_rdata, 8'h4E);

        // Three back-to-back writes with req_valid held high.
        base = tx_log.size();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = TX_DATA_ADDR;
        req_wdata = 8'h01;
        for (int k = 0; k < 3; k++) begin
            int n;
            n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("b2b_ready", req_ready, 1'b1);
            acc[k] = cyc;
            @(negedge clk);
            check("b2b_wdata", bus.wb_data_out, 32'(k + 1));
            if (k < 2) req_wdata = 8'(k + 2);
            else       req_valid = 1'b0;
        end
        wait_rsp(20, got, lat);
        check("b2b_last_rsp", got, 1'b1);
        check("b2b_gap_1", acc[1] - acc[0], 6);
        check("b2b_gap_2", acc[2] - acc[1], 6);
        check("b2b_log_size", tx_log.size() - base, 3);
        for (int k = 0; k < 3; k++)
            if (base + k < tx_log.size())
                check("b2b_order", tx_log[base + k], 32'(k + 1));

        // Responder never acks.
        ack_en = 1'b0;
        issue(1'b0, RX_DATA_ADDR, 8'h00, ok);
        check("tmo_accept", ok, 1'b1);
`ifdef WB_MASTER_TIMEOUT_EN
        wait_rsp(60, got, lat);
        check("tmo_rsp", got, 1'b1);
        check("tmo_latency", lat, 17);
        check("tmo_fields", {rsp_timeout, rsp_rdata}, {1'b1, 8'h00});
        @(negedge clk);
        check("tmo_bus_idle", {bus.wb_stb, bus.wb_clk, rsp_valid}, {1'b0, 1'b0, 1'b0});
        check("tmo_ready", req_ready, 1'b1);
        ack_en = 1'b1;
`else
        wait_rsp(40, got, lat);
        check("noto_no_rsp", got, 1'b0);
        check("noto_bus_held", {bus.wb_stb, bus.wb_clk}, {1'b1, 1'b1});
        ack_en = 1'b1;
        wait_rsp(20, got, lat);
        check("noto_late_rsp", got, 1'b1);
        check("noto_fields", {rsp_timeout, rsp_rdata}, {1'b0, 8'h5A});
`endif

        // Reset during STROBE while the responder keeps ack high.
        issue(1'b1, TX_DATA_ADDR, 8'h77, ok);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_ack_high", {bus.wb_ack, bus.wb_stb, bus.wb_clk}, {1'b1, 1'b1, 1'b1});
        #1;
        c0 = rsp_count;
        hold_ack = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid_outputs",
              {bus.wb_stb, bus.wb_clk, bus.wb_we, bus.wb_addr, bus.wb_data_out,
               rsp_valid, rsp_timeout, rsp_rdata},
              {1'b0, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00});
        check("rst_mid_ready", req_ready, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = TX_DATA_ADDR;
        repeat (3) begin
            @(negedge clk);
            check("stale_ack_ready", req_ready, 1'b0);
        end
        check("stale_ack_no_accept", bus.wb_stb, 1'b0);
        req_valid = 1'b0;
        hold_ack  = 1'b0;
        @(negedge clk);
        check("ack_drop_ready", req_ready, 1'b1);
        #1;
        check("rst_no_rsp", rsp_count - c0, 0);

        @(negedge clk); #1;
        check("rsp_never_b2b", rsp_b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
